mem_stage_reg: RTL and testbench
================================

Name: mem_stage_reg

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Latches the execute-stage payload through the valid/allowin handshake.
- Captures synchronous data-SRAM read data, including buffering it across write-back stalls.
- Performs byte/half/word load extraction with sign/zero extension. Sends the final result to write-back and the bypass bus to decode.

Parameters:
- None. Widths are fixed by the pipeline bus formats.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- ms_allowin  out  1  stage can accept a new instruction this cycle.
- es_to_ms_valid  in  1  execute stage presents a valid instruction.
- es_rf_collect  in  39  {res_from_mem, rf_we, rf_waddr[4:0], ex_result[31:0]}.
- es_mem_inst_bus  in  5  load type one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
- es_pc  in  32  PC of the instruction in execute.
- data_sram_rdata  in  32  data SRAM read data, valid the cycle after request (1-cycle sync read).
- ws_allowin  in  1  write-back stage can accept.
- ms_to_ws_valid  out  1  valid instruction offered to write-back.
- ms_to_ws_bus  out  70  {ms_rf_we, ms_rf_waddr[4:0], ms_final_result[31:0], ms_pc[31:0]}.
- ms_rf_collect  out  39  {res_from_mem&ms_valid, rf_we&ms_valid, rf_waddr, ms_final_result}, used for decode bypass/interlock.

Behaviour:
- ms_ready_go = 1. The SRAM returns data during the first MEM cycle.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- ms_valid:
  - async reset to 0.
  - at posedge, if ms_allowin, load es_to_ms_valid.
- Payload registers (res_from_mem, rf_we, rf_waddr, ex_result, ld type, pc):
  - async reset to 0.
  - load when es_to_ms_valid & ms_allowin; otherwise hold.
- Read-data buffer (rbuf[31:0], rbuf_valid), async reset to 0. At posedge:
  - if ms_allowin: rbuf_valid <= 0.
  - else if ms_valid & res_from_mem & ~rbuf_valid: rbuf <= data_sram_rdata, rbuf_valid <= 1.
  - Once set, rbuf holds until the instruction leaves. Later SRAM output changes (e.g. execute re-presenting a request while stalled) must not alter the result.
- raw = rbuf_valid ? rbuf : data_sram_rdata.
- Byte lane select uses a = ex_result[1:0]:
  - byte = raw[8a+7 : 8a].
  - half = ex_result[1] ? raw[31:16] : raw[15:0]. Bit 0 is ignored for halves.
  - ld_w ignores a.
- Load decode priority is ld_w > ld_h > ld_hu > ld_b > ld_bu:
  - ld_b / ld_h: sign-extend to 32.
  - ld_bu / ld_hu: zero-extend to 32.
  - res_from_mem with an all-zero type: treated as ld_w.
- ms_final_result = res_from_mem ? load_data : ex_result.
- ms_to_ws_bus.ms_rf_we = rf_we & ms_valid. A bubble never produces a register write.
- All outputs at reset:
  - ms_to_ws_valid = 0.
  - ms_allowin = 1.
  - ms_to_ws_bus = 0.
  - ms_rf_collect = 0.
- Reset asserted mid-operation: state clears immediately, without waiting for clk. The in-flight instruction is dropped; no write-back request is issued.
- Simultaneous drain and fill (ms_valid, ws_allowin=1, es_to_ms_valid=1): new payload replaces the old in the same edge, and rbuf_valid clears.
- Drain without fill: ms_valid -> 0 and the payload holds its stale value. This is harmless because every output valid qualifier is gated by ms_valid.

Test Plan:
- Reset: hold resetn=0 with random inputs -> ms_to_ws_valid=0, ms_allowin=1, ms_rf_collect=0. Release reset between clock edges -> no spurious valid.
- ALU pass-through: es_rf_collect={0,1,5'd3,32'h1234_5678}, pc=32'h1c00_0010, ws_allowin=1 -> next cycle ms_to_ws_bus={1,3,32'h1234_5678,32'h1c00_0010}, ms_to_ws_valid=1.
- Byte loads: rdata=32'h80FF_7F01, ld_b at addr ...02 -> 32'hFFFF_FFFF; ld_bu at addr ...03 -> 32'h0000_0080; ld_b at addr ...00 -> 32'h0000_0001.
- Half/word loads: rdata=32'h8001_7FFE, ld_h at addr ...02 -> 32'hFFFF_8001; ld_hu at addr ...00 -> 32'h0000_7FFE; ld_w at addr ...01 -> 32'h8001_7FFE.
- Stall buffering: ld_w enters with rdata=32'hDEAD_BEEF and ws_allowin=0 for 3 cycles, rdata changes to 32'h0 after cycle 1 -> ms_final_result stays 32'hDEAD_BEEF throughout, ms_allowin=0. Raise ws_allowin -> handed off, then rbuf_valid=0.
- Back-to-back and async reset: three valid instructions with ws_allowin=1 -> three consecutive ms_to_ws_valid pulses, no gaps. Assert resetn=0 mid-stall -> ms_to_ws_valid and ms_rf_collect[37] drop to 0 immediately.

Source files
------------

// File: rtl/mem_stage_reg.sv
// Memory-access pipeline stage: latches the execute payload, captures and holds
// synchronous data-SRAM read data across write-back stalls, and extracts loads.
module mem_stage_reg (
    input  logic        clk,
    input  logic        resetn,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [38:0] es_rf_collect,
    input  logic [4:0]  es_mem_inst_bus,
    input  logic [31:0] es_pc,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [38:0] ms_rf_collect
);

    // Handshake: a transfer into this stage happens on a rising edge where
    // es_to_ms_valid & ms_allowin; a transfer out happens where
    // ms_to_ws_valid & ws_allowin. Valid never depends on the downstream allowin.
    logic        ms_valid;
    logic        ms_ready_go;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [4:0]  ld_type;
    logic [31:0] ms_pc;
    logic [31:0] rbuf;
    logic        rbuf_valid;
    logic [31:0] raw;
    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic [31:0] load_data;
    logic [31:0] ms_final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_from_mem <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            ex_result    <= 32'd0;
            ld_type      <= 5'd0;
            ms_pc        <= 32'd0;
        end else if (es_to_ms_valid && ms_allowin) begin
            res_from_mem <= es_rf_collect[38];
            rf_we        <= es_rf_collect[37];
            rf_waddr     <= es_rf_collect[36:32];
            ex_result    <= es_rf_collect[31:0];
            ld_type      <= es_mem_inst_bus;
            ms_pc        <= es_pc;
        end
    end

    // The SRAM output is only trustworthy in the first MEM cycle; freeze it on
    // the first stalled edge so a re-presented request cannot corrupt the load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbuf       <= 32'd0;
            rbuf_valid <= 1'b0;
        end else if (ms_allowin) begin
            rbuf_valid <= 1'b0;
        end else if (ms_valid && res_from_mem && !rbuf_valid) begin
            rbuf       <= data_sram_rdata;
            rbuf_valid <= 1'b1;
        end
    end

    assign raw = rbuf_valid ? rbuf : data_sram_rdata;

    always_comb begin
        byte_data = raw[7:0];
        case (ex_result[1:0])
            2'd0:    byte_data = raw[7:0];
            2'd1:    byte_data = raw[15:8];
            2'd2:    byte_data = raw[23:16];
            default: byte_data = raw[31:24];
        endcase
        half_data = ex_result[1] ? raw[31:16] : raw[15:0];
    end

    // Load type bits are {ld_w, ld_h, ld_hu, ld_b, ld_bu}; no type means word.
    always_comb begin
        load_data = raw;
        if (ld_type[4]) begin
            load_data = raw;
        end else if (ld_type[3]) begin
            load_data = {{16{half_data[15]}}, half_data};
        end else if (ld_type[2]) begin
            load_data = {16'd0, half_data};
        end else if (ld_type[1]) begin
            load_data = {{24{byte_data[7]}}, byte_data};
        end else if (ld_type[0]) begin
            load_data = {24'd0, byte_data};
        end
    end

    assign ms_final_result = res_from_mem ? load_data : ex_result;

    assign ms_to_ws_bus  = {rf_we & ms_valid, rf_waddr, ms_final_result, ms_pc};
    assign ms_rf_collect = {res_from_mem & ms_valid, rf_we & ms_valid, rf_waddr, ms_final_result};

endmodule

// File: tb/tb_mem_stage_reg.sv
// Self-checking bench for mem_stage_reg: directed loads, stall buffering,
// back-to-back flow, asynchronous reset and a randomized scoreboard phase.
module tb_mem_stage_reg;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [38:0] es_rf_collect;
    logic [4:0]  es_mem_inst_bus;
    logic [31:0] es_pc;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_rf_collect;

    localparam logic [4:0] LD_W  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b00100;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00001;

    logic [108:0] exp_q[$];
    logic [108:0] exp_e;
    int           n_checks = 0;
    int           n_err    = 0;
    int           handoffs = 0;
    logic         acc;
    logic         scramble = 1'b0;

    mem_stage_reg dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_rf_collect   (es_rf_collect),
        .es_mem_inst_bus (es_mem_inst_bus),
        .es_pc           (es_pc),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_rf_collect   (ms_rf_collect)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: {ms_rf_collect, ms_to_ws_bus} for an instruction that hands off.
    function automatic logic [108:0] model(input logic [38:0] c, input logic [4:0] ld,
                                           input logic [31:0] pc, input logic [31:0] rd);
        logic [31:0] sh_b, sh_h, ld_v, res;
        sh_b = rd >> {c[1:0], 3'b000};
        sh_h = rd >> {c[1], 4'b0000};
        casez (ld)
            5'b1????: ld_v = rd;
            5'b01???: ld_v = {{16{sh_h[15]}}, sh_h[15:0]};
            5'b001??: ld_v = {16'd0, sh_h[15:0]};
            5'b0001?: ld_v = {{24{sh_b[7]}}, sh_b[7:0]};
            5'b00001: ld_v = {24'd0, sh_b[7:0]};
            default:  ld_v = rd;
        endcase
        res = c[38] ? ld_v : c[31:0];
        return {c[38], c[37], c[36:32], res, c[37], c[36:32], res, pc};
    endfunction

    // driver: entered just after a rising edge, returns at the falling edge
    task automatic step_drive(input logic v, input logic [38:0] c, input logic [4:0] ld,
                              input logic [31:0] pc, input logic [31:0] rd, input logic wsa);
        es_to_ms_valid  = v;
        es_rf_collect   = c;
        es_mem_inst_bus = ld;
        es_pc           = pc;
        ws_allowin      = wsa;
        @(negedge clk);
        acc = v && ms_allowin;
        if (acc) exp_q.push_back(model(c, ld, pc, rd));
    endtask

    // SRAM model: read data appears the cycle after the request is accepted
    task automatic step_finish(input logic [31:0] rd);
        @(posedge clk);
        #1;
        if (acc) data_sram_rdata = rd;
        else data_sram_rdata = scramble ? $urandom : 32'h0;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic step(input logic v, input logic [38:0] c, input logic [4:0] ld,
                        input logic [31:0] pc, input logic [31:0] rd, input logic wsa);
        step_drive(v, c, ld, pc, rd, wsa);
        step_finish(rd);
    endtask

    task automatic idle_step(input logic wsa);
        step(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, wsa);
    endtask

    task automatic do_load(input string tag, input logic [4:0] ld, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp_res);
        step(1'b1, {1'b1, 1'b1, 5'd7, addr}, ld, 32'h1c00_0100, rd, 1'b1);
        step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        check(tag, 128'(ms_to_ws_bus[63:32]), 128'(exp_res));
        step_finish(32'd0);
    endtask

    // scoreboard: pop on every write-back handoff
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            handoffs++;
            if (exp_q.size() == 0) begin
                check("unexpected_handoff", 128'(1), 128'(0));
            end else begin
                exp_e = exp_q.pop_front();
                check("ws_bus", 128'(ms_to_ws_bus), 128'(exp_e[69:0]));
                check("rf_collect", 128'(ms_rf_collect), 128'(exp_e[108:70]));
            end
        end
    end

    initial begin
        int h0;
        logic [4:0] rld;
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_rf_collect   = 39'd0;
        es_mem_inst_bus = 5'd0;
        es_pc           = 32'd0;
        data_sram_rdata = 32'd0;
        ws_allowin      = 1'b0;

        // reset with random inputs
        repeat (3) begin
            es_to_ms_valid  = 1'($urandom_range(0, 1));
            es_rf_collect   = {7'($urandom), 32'($urandom)};
            es_mem_inst_bus = 5'($urandom);
            es_pc           = $urandom;
            data_sram_rdata = $urandom;
            ws_allowin      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_valid", 128'(ms_to_ws_valid), 128'(0));
            check("rst_allowin", 128'(ms_allowin), 128'(1));
            check("rst_collect", 128'(ms_rf_collect), 128'(0));
            check("rst_bus", 128'(ms_to_ws_bus), 128'(0));
        end
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 128'(ms_to_ws_valid), 128'(0));

        // ALU pass-through
        step(1'b1, {1'b0, 1'b1, 5'd3, 32'h1234_5678}, 5'd0, 32'h1c00_0010, 32'hA5A5_A5A5, 1'b1);
        step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        check("alu_valid", 128'(ms_to_ws_valid), 128'(1));
        check("alu_bus", 128'(ms_to_ws_bus), 128'({1'b1, 5'd3, 32'h1234_5678, 32'h1c00_0010}));
        step_finish(32'd0);

        // byte / half / word loads
        do_load("ld_b_a2",  LD_B,  32'h1000_0002, 32'h80FF_7F01, 32'hFFFF_FFFF);
        do_load("ld_bu_a3", LD_BU, 32'h1000_0003, 32'h80FF_7F01, 32'h0000_0080);
        do_load("ld_b_a0",  LD_B,  32'h1000_0000, 32'h80FF_7F01, 32'h0000_0001);
        do_load("ld_h_a2",  LD_H,  32'h1000_0002, 32'h8001_7FFE, 32'hFFFF_8001);
        do_load("ld_hu_a0", LD_HU, 32'h1000_0000, 32'h8001_7FFE, 32'h0000_7FFE);
        do_load("ld_w_a1",  LD_W,  32'h1000_0001, 32'h8001_7FFE, 32'h8001_7FFE);
        do_load("ld_none",  5'd0,  32'h1000_0003, 32'h8001_7FFE, 32'h8001_7FFE);
        do_load("ld_prio",  LD_H | LD_B, 32'h1000_0001, 32'h8001_7FFE, 32'h0000_7FFE);
        do_load("ld_h_a3",  LD_H,  32'h1000_0003, 32'h8001_7FFE, 32'hFFFF_8001);

        // stall buffering: SRAM output changes and execute re-presents while stalled
        step(1'b1, {1'b1, 1'b1, 5'd9, 32'h2000_0000}, LD_W, 32'h1c00_0200, 32'hDEAD_BEEF, 1'b1);
        step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("stall1_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hDEAD_BEEF));
        check("stall1_allowin", 128'(ms_allowin), 128'(0));
        step_finish(32'd0);
        repeat (2) begin
            step_drive(1'b1, {1'b1, 1'b1, 5'd10, 32'h2000_0004}, LD_W, 32'h1c00_0204, 32'hCAFE_F00D, 1'b0);
            check("stall_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hDEAD_BEEF));
            check("stall_allowin", 128'(ms_allowin), 128'(0));
            step_finish(32'hCAFE_F00D);
        end
        step(1'b1, {1'b1, 1'b1, 5'd10, 32'h2000_0004}, LD_W, 32'h1c00_0204, 32'hCAFE_F00D, 1'b1);
        step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        check("after_stall_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hCAFE_F00D));
        step_finish(32'd0);

        // back-to-back flow
        h0 = handoffs;
        step(1'b1, {1'b0, 1'b1, 5'd1, 32'h0000_0011}, 5'd0, 32'h1c00_0300, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < 2)
                step_drive(1'b1, {1'b0, 1'b1, 5'(i + 2), 32'(i + 32'h22)}, 5'd0, 32'(32'h1c00_0304 + 4 * i), 32'd0, 1'b1);
            else
                step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b1);
            check("b2b_valid", 128'(ms_to_ws_valid), 128'(1));
            step_finish(32'd0);
        end
        check("b2b_count", 128'(handoffs - h0), 128'(3));

        // asynchronous reset while stalled
        step(1'b1, {1'b0, 1'b1, 5'd4, 32'h0000_0055}, 5'd0, 32'h1c00_0400, 32'd0, 1'b1);
        step_drive(1'b0, 39'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("pre_rst_we", 128'(ms_rf_collect[37]), 128'(1));
        step_finish(32'd0);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", 128'(ms_to_ws_valid), 128'(0));
        check("arst_we", 128'(ms_rf_collect[37]), 128'(0));
        check("arst_allowin", 128'(ms_allowin), 128'(1));
        exp_q.delete();
        @(negedge clk);
        #2 resetn = 1'b1;
        ws_allowin = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_valid", 128'(ms_to_ws_valid), 128'(0));

        // randomized traffic with random write-back stalls
        scramble = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: rld = LD_W;
                1: rld = LD_H;
                2: rld = LD_HU;
                3: rld = LD_B;
                4: rld = LD_BU;
                5: rld = 5'd0;
                default: rld = 5'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), {7'($urandom), 32'($urandom)}, rld, $urandom,
                 $urandom, 1'($urandom_range(0, 3) != 0));
        end
        repeat (3) idle_step(1'b1);
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
